// File: rtl/xfft_frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// xfft_frame_sequencer_if
// Groups the AXI-Stream style channels between the frame sequencer and the
// xfft_0 core: the configuration channel, the input data channel, the output
// data status (valid/last only) and the two core event lines.
//   master : sequencer side (drives config/data, observes readys and status)
//   slave  : FFT core side
// -----------------------------------------------------------------------------
interface xfft_frame_sequencer_if #(
  parameter int CFG_WIDTH = 8
);
  logic [CFG_WIDTH-1:0] s_axis_config_tdata;
  logic                 s_axis_config_tvalid;
  logic                 s_axis_config_tready;
  logic [15:0]          s_axis_data_tdata;
  logic                 s_axis_data_tvalid;
  logic                 s_axis_data_tlast;
  logic                 s_axis_data_tready;
  logic                 m_axis_data_tvalid;
  logic                 m_axis_data_tlast;
  logic                 event_tlast_unexpected;
  logic                 event_tlast_missing;

  modport master (
    output s_axis_config_tdata, s_axis_config_tvalid,
    input  s_axis_config_tready,
    output s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast,
    input  s_axis_data_tready,
    input  m_axis_data_tvalid, m_axis_data_tlast,
    input  event_tlast_unexpected, event_tlast_missing
  );

  modport slave (
    input  s_axis_config_tdata, s_axis_config_tvalid,
    output s_axis_config_tready,
    input  s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast,
    output s_axis_data_tready,
    output m_axis_data_tvalid, m_axis_data_tlast,
    output event_tlast_unexpected, event_tlast_missing
  );
endinterface

// File: rtl/xfft_frame_sequencer.sv
// -----------------------------------------------------------------------------
// xfft_frame_sequencer
// Issues one FFT configuration word, then streams DDS samples into the FFT in
// frames of 2^NFFT_LOG2 beats (tlast on the final beat), counts frames in and
// out of the core and reports completion and sticky error status.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   clk_enable          global enable, all state frozen when low
//   start, stop         run start pulse (IDLE only), continuous-run stop pulse
//   num_frames          frames per run, 0 = continuous until stop
//   fwd_inv             FFT direction, latched at start
//   dds_tdata/tvalid    DDS sample stream (cannot be stalled)
//   fft                 FFT core channels (master side of the interface)
//   busy, done          run in progress, one-cycle completion pulse
//   error               sticky {tlast_missing, tlast_unexpected, overrun}
//   frames_out          FFT output frames completed in this run
// -----------------------------------------------------------------------------
module xfft_frame_sequencer #(
  parameter int NFFT_LOG2 = 10,
  parameter int CFG_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_enable,
  input  logic                   start,
  input  logic                   stop,
  input  logic [15:0]            num_frames,
  input  logic                   fwd_inv,
  input  logic [7:0]             dds_tdata,
  input  logic                   dds_tvalid,
  xfft_frame_sequencer_if.master fft,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             error,
  output logic [15:0]            frames_out
);

  localparam logic [NFFT_LOG2-1:0] LAST_IDX = '1;
  localparam logic [NFFT_LOG2-1:0] CNT_ONE  = {{(NFFT_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONFIG = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           nframes_q, nframes_d;
  logic                  fwd_q, fwd_d;
  logic                  stop_pend_q, stop_pend_d;
  logic [NFFT_LOG2-1:0]  sample_cnt_q, sample_cnt_d;
  logic [15:0]           frames_in_q, frames_in_d;
  logic [15:0]           frames_out_q, frames_out_d;
  logic [2:0]            err_q, err_d;
  logic                  dvld_q, dvld_d;
  logic                  dlast_q, dlast_d;
  logic [7:0]            ddata_q, ddata_d;
  logic                  done_q, done_d;

  logic                  cfg_hs;
  logic                  data_hs;
  logic                  last_hs;
  logic                  final_frame;
  logic                  load_ok;
  logic                  load;
  logic [NFFT_LOG2-1:0]  load_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      nframes_q    <= '0;
      fwd_q        <= 1'b0;
      stop_pend_q  <= 1'b0;
      sample_cnt_q <= '0;
      frames_in_q  <= '0;
      frames_out_q <= '0;
      err_q        <= '0;
      dvld_q       <= 1'b0;
      dlast_q      <= 1'b0;
      ddata_q      <= '0;
      done_q       <= 1'b0;
    end else if (clk_enable) begin
      state_q      <= state_d;
      nframes_q    <= nframes_d;
      fwd_q        <= fwd_d;
      stop_pend_q  <= stop_pend_d;
      sample_cnt_q <= sample_cnt_d;
      frames_in_q  <= frames_in_d;
      frames_out_q <= frames_out_d;
      err_q        <= err_d;
      dvld_q       <= dvld_d;
      dlast_q      <= dlast_d;
      ddata_q      <= ddata_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    nframes_d    = nframes_q;
    fwd_d        = fwd_q;
    stop_pend_d  = stop_pend_q;
    sample_cnt_d = sample_cnt_q;
    frames_in_d  = frames_in_q;
    frames_out_d = frames_out_q;
    err_d        = err_q;
    dvld_d       = dvld_q;
    dlast_d      = dlast_q;
    ddata_d      = ddata_q;
    done_d       = 1'b0;

    cfg_hs  = (state_q == S_CONFIG) && fft.s_axis_config_tready;
    data_hs = dvld_q && fft.s_axis_data_tready;
    last_hs = data_hs && dlast_q;

    // The frame currently being sent is the last one of the run when a stop is
    // pending (or arrives now) or it brings frames_in up to num_frames.
    final_frame = stop_pend_q || stop ||
                  ((nframes_q != 16'd0) && ((frames_in_q + 16'd1) == nframes_q));

    // Once the closing tlast beat of the final frame sits in the holding
    // register, nothing else may follow it into the core.
    load_ok  = (state_q == S_STREAM) && !(dvld_q && dlast_q && final_frame);
    load     = load_ok && dds_tvalid && (!dvld_q || fft.s_axis_data_tready);
    // Index of the beat being loaded: the held beat (if any) is leaving now.
    load_idx = data_hs ? (sample_cnt_q + CNT_ONE) : sample_cnt_q;

    if (data_hs) begin
      sample_cnt_d = sample_cnt_q + CNT_ONE;
    end

    if (load) begin
      dvld_d  = 1'b1;
      ddata_d = dds_tdata;
      dlast_d = (load_idx == LAST_IDX);
    end else if (data_hs) begin
      dvld_d  = 1'b0;
      dlast_d = 1'b0;
    end

    if (last_hs) begin
      frames_in_d = frames_in_q + 16'd1;
    end

    if ((state_q != S_IDLE) && fft.m_axis_data_tvalid && fft.m_axis_data_tlast) begin
      frames_out_d = frames_out_q + 16'd1;
    end

    // A sample that can neither be held nor replace a departing beat is lost.
    if ((state_q == S_STREAM) && dds_tvalid && dvld_q && !fft.s_axis_data_tready) begin
      err_d[0] = 1'b1;
    end

    if ((state_q == S_STREAM) && stop) begin
      stop_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          nframes_d    = num_frames;
          fwd_d        = fwd_inv;
          stop_pend_d  = 1'b0;
          sample_cnt_d = '0;
          frames_in_d  = '0;
          frames_out_d = '0;
          err_d        = '0;
          dvld_d       = 1'b0;
          dlast_d      = 1'b0;
          state_d      = S_CONFIG;
        end
      end
      S_CONFIG: begin
        if (cfg_hs) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (last_hs && final_frame) begin
          stop_pend_d = 1'b0;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Equality rather than ordering keeps this valid across 16-bit wrap.
        if (frames_out_q == frames_in_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Core events are sticky and recorded in every state, including the start cycle.
    err_d = err_d | {fft.event_tlast_missing, fft.event_tlast_unexpected, 1'b0};
  end

  assign fft.s_axis_config_tdata  = {{(CFG_WIDTH-1){1'b0}}, fwd_q};
  assign fft.s_axis_config_tvalid = (state_q == S_CONFIG);
  assign fft.s_axis_data_tdata    = {8'h00, ddata_q};
  assign fft.s_axis_data_tvalid   = dvld_q;
  assign fft.s_axis_data_tlast    = dlast_q;

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign error      = err_q;
  assign frames_out = frames_out_q;

endmodule

// File: tb/tb_xfft_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_xfft_frame_sequencer
// Directed bench for xfft_frame_sequencer with NFFT_LOG2=3 (8-beat frames).
// A small FFT stand-in returns one output tlast a fixed number of cycles after
// each input tlast handshake. A negedge monitor counts beats, frames, config
// beats and done pulses; scenarios compare deltas against hand-derived values.
// -----------------------------------------------------------------------------
module tb_xfft_frame_sequencer;

  localparam int NL = 3;
  localparam int N  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] num_frames = 16'd0;
  logic        fwd_inv = 1'b0;
  logic [7:0]  dds_tdata = 8'd0;
  logic        dds_tvalid = 1'b0;
  logic        busy;
  logic        done;
  logic [2:0]  error;
  logic [15:0] frames_out;

  xfft_frame_sequencer_if #(.CFG_WIDTH(8)) fft ();

  xfft_frame_sequencer #(.NFFT_LOG2(NL), .CFG_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .start      (start),
    .stop       (stop),
    .num_frames (num_frames),
    .fwd_inv    (fwd_inv),
    .dds_tdata  (dds_tdata),
    .dds_tvalid (dds_tvalid),
    .fft        (fft),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .frames_out (frames_out)
  );

  always #5 clk = ~clk;

  // FFT stand-in: output frame ends 5 enabled cycles after an input tlast beat.
  logic [4:0] fft_sr;
  always @(posedge clk or posedge reset) begin
    if (reset) fft_sr <= '0;
    else if (clk_enable)
      fft_sr <= {fft_sr[3:0],
                 fft.s_axis_data_tvalid & fft.s_axis_data_tready & fft.s_axis_data_tlast};
  end
  assign fft.m_axis_data_tvalid = fft_sr[4];
  assign fft.m_axis_data_tlast  = fft_sr[4];

  // Monitor
  int beats = 0, tlasts = 0, bad = 0, fr_beats = 0, cfg_beats = 0, done_cnt = 0;
  logic [7:0] cfg_last = 8'd0;
  always @(negedge clk) begin
    if (reset) begin
      fr_beats = 0;
    end else if (clk_enable) begin
      if (fft.s_axis_config_tvalid && fft.s_axis_config_tready) begin
        cfg_beats = cfg_beats + 1;
        cfg_last  = fft.s_axis_config_tdata;
      end
      if (fft.s_axis_data_tvalid && fft.s_axis_data_tready) begin
        beats    = beats + 1;
        fr_beats = fr_beats + 1;
        if (fft.s_axis_data_tlast) begin
          tlasts = tlasts + 1;
          if (fr_beats != N) bad = bad + 1;
          fr_beats = 0;
        end else if (fr_beats == N) begin
          bad = bad + 1;
        end
      end
      if (done) done_cnt = done_cnt + 1;
    end
  end

  int b_beats, b_tlasts, b_bad, b_cfg, b_done;
  task automatic mark();
    b_beats  = beats;
    b_tlasts = tlasts;
    b_bad    = bad;
    b_cfg    = cfg_beats;
    b_done   = done_cnt;
  endtask

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (dds_tvalid) dds_tdata = dds_tdata + 8'd1;
    end
  endtask

  task automatic run_start(input logic [15:0] nf, input logic fw);
    num_frames = nf;
    fwd_inv    = fw;
    start      = 1'b1;
    cyc(1);
    start      = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else     chk({tag, "_done_at_idle"}, 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input string tag, input int target, input int max);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (beats >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({tag, "_beat_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    fft.s_axis_config_tready   = 1'b1;
    fft.s_axis_data_tready     = 1'b1;
    fft.event_tlast_unexpected = 1'b0;
    fft.event_tlast_missing    = 1'b0;

    // Reset state
    cyc(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cfg_tvalid", 32'(fft.s_axis_config_tvalid), 32'd0);
    chk("rst_data_tvalid", 32'(fft.s_axis_data_tvalid), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_frames_out", 32'(frames_out), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    dds_tvalid = 1'b1;
    cyc(2);

    // Normal run: 2 frames, forward
    mark();
    run_start(16'd2, 1'b1);
    fwd_inv = 1'b0;
    chk("norm_cfg_tvalid", 32'(fft.s_axis_config_tvalid), 32'd1);
    chk("norm_cfg_tdata", 32'(fft.s_axis_config_tdata), 32'h01);
    wait_idle("norm", 200);
    chk("norm_beats", 32'(beats - b_beats), 32'd16);
    chk("norm_tlasts", 32'(tlasts - b_tlasts), 32'd2);
    chk("norm_tlast_pos", 32'(bad - b_bad), 32'd0);
    chk("norm_cfg_beats", 32'(cfg_beats - b_cfg), 32'd1);
    chk("norm_cfg_last", 32'(cfg_last), 32'h01);
    chk("norm_done_cnt", 32'(done_cnt - b_done), 32'd1);
    chk("norm_frames_out", 32'(frames_out), 32'd2);
    chk("norm_error", 32'(error), 32'd0);

    // Backpressure: tready low 3 cycles with continuous DDS
    mark();
    run_start(16'd2, 1'b0);
    wait_beats("bp", b_beats + 4, 100);
    fft.s_axis_data_tready = 1'b0;
    cyc(3);
    fft.s_axis_data_tready = 1'b1;
    wait_idle("bp", 300);
    chk("bp_error", 32'(error), 32'h1);
    chk("bp_beats", 32'(beats - b_beats), 32'd16);
    chk("bp_tlasts", 32'(tlasts - b_tlasts), 32'd2);
    chk("bp_tlast_pos", 32'(bad - b_bad), 32'd0);
    chk("bp_cfg_last", 32'(cfg_last), 32'h00);
    chk("bp_frames_out", 32'(frames_out), 32'd2);

    // Continuous run ended by stop during frame 2
    mark();
    run_start(16'd0, 1'b1);
    wait_beats("stop", b_beats + N + 3, 200);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    wait_idle("stop", 300);
    chk("stop_beats", 32'(beats - b_beats), 32'd16);
    chk("stop_tlasts", 32'(tlasts - b_tlasts), 32'd2);
    chk("stop_tlast_pos", 32'(bad - b_bad), 32'd0);
    chk("stop_frames_out", 32'(frames_out), 32'd2);
    chk("stop_done_cnt", 32'(done_cnt - b_done), 32'd1);
    chk("stop_error", 32'(error), 32'd0);
    cyc(10);
    chk("stop_no_more_beats", 32'(beats - b_beats), 32'd16);
    chk("stop_idle", 32'(busy), 32'd0);

    // Event flag is sticky through done, cleared by the next start
    mark();
    run_start(16'd1, 1'b1);
    cyc(3);
    fft.event_tlast_missing = 1'b1;
    cyc(1);
    fft.event_tlast_missing = 1'b0;
    wait_idle("evt", 200);
    chk("evt_error_at_done", 32'(error), 32'h4);
    cyc(4);
    chk("evt_error_held", 32'(error), 32'h4);
    mark();
    run_start(16'd1, 1'b1);
    chk("evt_error_cleared", 32'(error), 32'h0);
    wait_idle("evt2", 200);
    chk("evt2_frames_out", 32'(frames_out), 32'd1);
    chk("evt2_beats", 32'(beats - b_beats), 32'd8);

    // clk_enable gating mid-frame
    mark();
    run_start(16'd1, 1'b1);
    wait_beats("ce", b_beats + 3, 100);
    clk_enable = 1'b0;
    cyc(5);
    chk("ce_busy_frozen", 32'(busy), 32'd1);
    chk("ce_frames_out_frozen", 32'(frames_out), 32'd0);
    clk_enable = 1'b1;
    wait_idle("ce", 200);
    chk("ce_beats", 32'(beats - b_beats), 32'd8);
    chk("ce_tlasts", 32'(tlasts - b_tlasts), 32'd1);
    chk("ce_tlast_pos", 32'(bad - b_bad), 32'd0);
    chk("ce_frames_out", 32'(frames_out), 32'd1);

    // Asynchronous reset mid-run, then a clean single-frame run
    mark();
    run_start(16'd2, 1'b1);
    wait_beats("mr", b_beats + 3, 100);
    fft.event_tlast_unexpected = 1'b1;
    cyc(1);
    fft.event_tlast_unexpected = 1'b0;
    chk("mr_error_set", 32'(error), 32'h2);
    #2;
    reset = 1'b1;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_data_tvalid", 32'(fft.s_axis_data_tvalid), 32'd0);
    chk("mr_cfg_tvalid", 32'(fft.s_axis_config_tvalid), 32'd0);
    chk("mr_error", 32'(error), 32'd0);
    chk("mr_frames_out", 32'(frames_out), 32'd0);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    mark();
    run_start(16'd1, 1'b0);
    wait_idle("mr2", 200);
    chk("mr2_frames_out", 32'(frames_out), 32'd1);
    chk("mr2_beats", 32'(beats - b_beats), 32'd8);
    chk("mr2_done_cnt", 32'(done_cnt - b_done), 32'd1);
    chk("mr2_error", 32'(error), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
